// File: rtl/gat_pkg.sv
// Shared definitions for the GAT load sequencer slice.
// Holds the default word width, FSM state encoding and an address-width helper.
package gat_pkg;

   localparam int TOP_WIDTH = 32;

   typedef enum logic [3:0] {
      IDLE,
      LD_H,
      LD_NI,
      LD_W,
      LD_SG,
      WAIT_GAT,
      RD_ADDR,
      RD_WAIT,
      RD_OUT,
      DONE
   } state_t;

   // Word-address width for a given depth; a depth of 1 still needs one bit.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/gat_seg_counter.sv
// Word counter for one segment: counts 0..DEPTH-1 and wraps to 0 on the last step.
// Ports: clk, rst (async high), clr (sync zero), inc (step), cnt (count), last (cnt==DEPTH-1).
module gat_seg_counter #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         last
);

   assign last = (cnt == W'(DEPTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= last ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/gat_load_sequencer.sv
// Loads four BRAM segments from one input stream, waits for the accelerator,
// then streams the result BRAM out. Ports: start/busy/done control, s_* load
// stream, four byte-addressed BRAM write ports with load_done flags, gat_ready,
// feat_bram read port (1-cycle latency) and m_* result stream.
module gat_load_sequencer
   import gat_pkg::*;
#(
   parameter int TOP_WIDTH          = gat_pkg::TOP_WIDTH,
   parameter int H_DATA_DEPTH       = 242101,
   parameter int NODE_INFO_DEPTH    = 13264,
   parameter int WEIGHT_DEPTH       = 22928,
   parameter int SUBGRAPH_IDX_DEPTH = 13264,
   parameter int NEW_FEATURE_DEPTH  = 43328,
   parameter int H_DATA_ADDR_W       = addr_w(H_DATA_DEPTH),
   parameter int NODE_INFO_ADDR_W    = addr_w(NODE_INFO_DEPTH),
   parameter int WEIGHT_ADDR_W       = addr_w(WEIGHT_DEPTH),
   parameter int SUBGRAPH_IDX_ADDR_W = addr_w(SUBGRAPH_IDX_DEPTH),
   parameter int NEW_FEATURE_ADDR_W  = addr_w(NEW_FEATURE_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,

   input  logic [TOP_WIDTH-1:0]          s_data,
   input  logic                          s_valid,
   output logic                          s_ready,

   output logic [TOP_WIDTH-1:0]          h_data_bram_din,
   output logic                          h_data_bram_ena,
   output logic                          h_data_bram_wea,
   output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra,

   output logic [TOP_WIDTH-1:0]          h_node_info_bram_din,
   output logic                          h_node_info_bram_ena,
   output logic                          h_node_info_bram_wea,
   output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,

   output logic [TOP_WIDTH-1:0]          wgt_bram_din,
   output logic                          wgt_bram_ena,
   output logic                          wgt_bram_wea,
   output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra,

   output logic [TOP_WIDTH-1:0]          subgraph_bram_din,
   output logic                          subgraph_bram_ena,
   output logic                          subgraph_bram_wea,
   output logic [SUBGRAPH_IDX_ADDR_W+1:0] subgraph_bram_addra,

   output logic                          h_data_bram_load_done,
   output logic                          h_node_info_bram_load_done,
   output logic                          wgt_bram_load_done,

   input  logic                          gat_ready,
   output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
   input  logic [TOP_WIDTH-1:0]          feat_bram_dout,

   output logic [TOP_WIDTH-1:0]          m_data,
   output logic                          m_valid,
   input  logic                          m_ready
);

   localparam int HW = H_DATA_ADDR_W;
   localparam int NW = NODE_INFO_ADDR_W;
   localparam int WW = WEIGHT_ADDR_W;
   localparam int SW = SUBGRAPH_IDX_ADDR_W;
   localparam int FW = NEW_FEATURE_ADDR_W;

   state_t state;

   logic          launch;
   logic          beat;
   logic          h_inc, ni_inc, w_inc, sg_inc, rd_inc;
   logic [HW-1:0] h_cnt;
   logic [NW-1:0] ni_cnt;
   logic [WW-1:0] w_cnt;
   logic [SW-1:0] sg_cnt;
   logic [FW-1:0] rd_cnt;
   logic          h_last, ni_last, w_last, sg_last, rd_last;

   assign s_ready = (state == LD_H) | (state == LD_NI) |
                    (state == LD_W) | (state == LD_SG);
   assign beat    = s_valid & s_ready;
   assign busy    = (state != IDLE) & (state != DONE);
   assign done    = (state == DONE);
   assign launch  = start & ((state == IDLE) | (state == DONE));

   assign h_inc  = beat & (state == LD_H);
   assign ni_inc = beat & (state == LD_NI);
   assign w_inc  = beat & (state == LD_W);
   assign sg_inc = beat & (state == LD_SG);
   assign rd_inc = (state == RD_OUT) & m_ready;

   gat_seg_counter #(.DEPTH(H_DATA_DEPTH), .W(HW)) u_h_cnt (
      .clk(clk), .rst(rst), .clr(launch), .inc(h_inc),
      .cnt(h_cnt), .last(h_last)
   );

   gat_seg_counter #(.DEPTH(NODE_INFO_DEPTH), .W(NW)) u_ni_cnt (
      .clk(clk), .rst(rst), .clr(launch), .inc(ni_inc),
      .cnt(ni_cnt), .last(ni_last)
   );

   gat_seg_counter #(.DEPTH(WEIGHT_DEPTH), .W(WW)) u_w_cnt (
      .clk(clk), .rst(rst), .clr(launch), .inc(w_inc),
      .cnt(w_cnt), .last(w_last)
   );

   gat_seg_counter #(.DEPTH(SUBGRAPH_IDX_DEPTH), .W(SW)) u_sg_cnt (
      .clk(clk), .rst(rst), .clr(launch), .inc(sg_inc),
      .cnt(sg_cnt), .last(sg_last)
   );

   gat_seg_counter #(.DEPTH(NEW_FEATURE_DEPTH), .W(FW)) u_rd_cnt (
      .clk(clk), .rst(rst), .clr(launch), .inc(rd_inc),
      .cnt(rd_cnt), .last(rd_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                      <= IDLE;
         h_data_bram_din            <= '0;
         h_data_bram_ena            <= 1'b0;
         h_data_bram_wea            <= 1'b0;
         h_data_bram_addra          <= '0;
         h_node_info_bram_din       <= '0;
         h_node_info_bram_ena       <= 1'b0;
         h_node_info_bram_wea       <= 1'b0;
         h_node_info_bram_addra     <= '0;
         wgt_bram_din               <= '0;
         wgt_bram_ena               <= 1'b0;
         wgt_bram_wea               <= 1'b0;
         wgt_bram_addra             <= '0;
         subgraph_bram_din          <= '0;
         subgraph_bram_ena          <= 1'b0;
         subgraph_bram_wea          <= 1'b0;
         subgraph_bram_addra        <= '0;
         h_data_bram_load_done      <= 1'b0;
         h_node_info_bram_load_done <= 1'b0;
         wgt_bram_load_done         <= 1'b0;
         feat_bram_addrb            <= '0;
         m_data                     <= '0;
         m_valid                    <= 1'b0;
      end else begin
         // Write strobes are single-cycle: only a beat raises them.
         h_data_bram_ena      <= 1'b0;
         h_data_bram_wea      <= 1'b0;
         h_node_info_bram_ena <= 1'b0;
         h_node_info_bram_wea <= 1'b0;
         wgt_bram_ena         <= 1'b0;
         wgt_bram_wea         <= 1'b0;
         subgraph_bram_ena    <= 1'b0;
         subgraph_bram_wea    <= 1'b0;

         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state                      <= LD_H;
                  h_data_bram_load_done      <= 1'b0;
                  h_node_info_bram_load_done <= 1'b0;
                  wgt_bram_load_done         <= 1'b0;
               end
            end
            LD_H: begin
               if (beat) begin
                  h_data_bram_din   <= s_data;
                  h_data_bram_ena   <= 1'b1;
                  h_data_bram_wea   <= 1'b1;
                  h_data_bram_addra <= {h_cnt, 2'b00};
                  if (h_last) begin
                     state                 <= LD_NI;
                     h_data_bram_load_done <= 1'b1;
                  end
               end
            end
            LD_NI: begin
               if (beat) begin
                  h_node_info_bram_din   <= s_data;
                  h_node_info_bram_ena   <= 1'b1;
                  h_node_info_bram_wea   <= 1'b1;
                  h_node_info_bram_addra <= {ni_cnt, 2'b00};
                  if (ni_last) begin
                     state                      <= LD_W;
                     h_node_info_bram_load_done <= 1'b1;
                  end
               end
            end
            LD_W: begin
               if (beat) begin
                  wgt_bram_din   <= s_data;
                  wgt_bram_ena   <= 1'b1;
                  wgt_bram_wea   <= 1'b1;
                  wgt_bram_addra <= {w_cnt, 2'b00};
                  if (w_last) begin
                     state              <= LD_SG;
                     wgt_bram_load_done <= 1'b1;
                  end
               end
            end
            LD_SG: begin
               if (beat) begin
                  subgraph_bram_din   <= s_data;
                  subgraph_bram_ena   <= 1'b1;
                  subgraph_bram_wea   <= 1'b1;
                  subgraph_bram_addra <= {sg_cnt, 2'b00};
                  if (sg_last) begin
                     state <= WAIT_GAT;
                  end
               end
            end
            WAIT_GAT: begin
               if (gat_ready) begin
                  feat_bram_addrb <= '0;
                  state           <= RD_ADDR;
               end
            end
            RD_ADDR: begin
               // BRAM latches addrb on this edge.
               state <= RD_WAIT;
            end
            RD_WAIT: begin
               m_data  <= feat_bram_dout;
               m_valid <= 1'b1;
               state   <= RD_OUT;
            end
            RD_OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (rd_last) begin
                     state <= DONE;
                  end else begin
                     feat_bram_addrb <= {rd_cnt + FW'(1), 2'b00};
                     state           <= RD_ADDR;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gat_load_sequencer.sv
// Scoreboard bench for gat_load_sequencer with small segment depths.
// Writes and result words are queued at stimulus time and checked by a monitor.
module tb_gat_load_sequencer;

   localparam int HD  = 4;
   localparam int NID = 3;
   localparam int WD  = 2;
   localparam int SGD = 2;
   localparam int FD  = 3;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] h_din;
   logic        h_ena, h_wea;
   logic [3:0]  h_addra;
   logic [31:0] ni_din;
   logic        ni_ena, ni_wea;
   logic [3:0]  ni_addra;
   logic [31:0] w_din;
   logic        w_ena, w_wea;
   logic [2:0]  w_addra;
   logic [31:0] sg_din;
   logic        sg_ena, sg_wea;
   logic [2:0]  sg_addra;
   logic        h_done, ni_done, w_done;
   logic        gat_ready;
   logic [3:0]  feat_bram_addrb;
   logic [31:0] feat_bram_dout;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;

   gat_load_sequencer #(
      .TOP_WIDTH(32),
      .H_DATA_DEPTH(HD),
      .NODE_INFO_DEPTH(NID),
      .WEIGHT_DEPTH(WD),
      .SUBGRAPH_IDX_DEPTH(SGD),
      .NEW_FEATURE_DEPTH(FD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .busy(busy),
      .done(done),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .h_data_bram_din(h_din),
      .h_data_bram_ena(h_ena),
      .h_data_bram_wea(h_wea),
      .h_data_bram_addra(h_addra),
      .h_node_info_bram_din(ni_din),
      .h_node_info_bram_ena(ni_ena),
      .h_node_info_bram_wea(ni_wea),
      .h_node_info_bram_addra(ni_addra),
      .wgt_bram_din(w_din),
      .wgt_bram_ena(w_ena),
      .wgt_bram_wea(w_wea),
      .wgt_bram_addra(w_addra),
      .subgraph_bram_din(sg_din),
      .subgraph_bram_ena(sg_ena),
      .subgraph_bram_wea(sg_wea),
      .subgraph_bram_addra(sg_addra),
      .h_data_bram_load_done(h_done),
      .h_node_info_bram_load_done(ni_done),
      .wgt_bram_load_done(w_done),
      .gat_ready(gat_ready),
      .feat_bram_addrb(feat_bram_addrb),
      .feat_bram_dout(feat_bram_dout),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result BRAM: word at byte address a holds 0xA0 + a/4.
   always @(posedge clk) begin
      feat_bram_dout <= 32'hA0 + 32'(feat_bram_addrb[3:2]);
   end

   typedef struct packed {
      logic [1:0]  tgt;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         wq[$];
   logic [31:0] rq[$];
   int          vec;
   int          bad;

   int seg;
   int scnt;
   int total;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   logic [3:0]  mon_en;
   wr_t         mon_e;
   logic [1:0]  mon_t;
   logic [31:0] mon_a;
   logic [31:0] mon_d;
   logic        mon_w;

   always @(negedge clk) begin
      mon_en = {sg_ena, w_ena, ni_ena, h_ena};
      if (mon_en != 4'b0) begin
         if ($countones(mon_en) != 1 || wq.size() == 0) begin
            vec++;
            bad++;
            $display("FAIL wr_unexpected: ena=%b pending=%0d, expected no write",
                     mon_en, wq.size());
         end else begin
            mon_e = wq.pop_front();
            case (1'b1)
               mon_en[0]: begin
                  mon_t = 2'd0; mon_a = 32'(h_addra);
                  mon_d = h_din; mon_w = h_wea;
               end
               mon_en[1]: begin
                  mon_t = 2'd1; mon_a = 32'(ni_addra);
                  mon_d = ni_din; mon_w = ni_wea;
               end
               mon_en[2]: begin
                  mon_t = 2'd2; mon_a = 32'(w_addra);
                  mon_d = w_din; mon_w = w_wea;
               end
               default: begin
                  mon_t = 2'd3; mon_a = 32'(sg_addra);
                  mon_d = sg_din; mon_w = sg_wea;
               end
            endcase
            chk("wr_target", 32'(mon_t), 32'(mon_e.tgt));
            chk("wr_addra", mon_a, mon_e.addr);
            chk("wr_din", mon_d, mon_e.data);
            chk("wr_wea", 32'(mon_w), 32'd1);
         end
      end
      if (m_valid && m_ready) begin
         if (rq.size() == 0) begin
            vec++;
            bad++;
            $display("FAIL m_unexpected: m_data=%h with nothing pending", m_data);
         end else begin
            chk("m_data", m_data, rq.pop_front());
         end
      end
   end

   task automatic start_run();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      seg   = 0;
      scnt  = 0;
      total = 0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_done", 32'(done), 32'd0);
      chk("start_flags", {29'd0, w_done, ni_done, h_done}, 32'd0);
   endtask

   task automatic beat(input logic [31:0] d, input bit gap);
      int depth[4];
      wr_t e;
      depth = '{HD, NID, WD, SGD};
      chk("s_ready_load", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = d;
      e.tgt   = 2'(seg);
      e.addr  = 32'(scnt * 4);
      e.data  = d;
      wq.push_back(e);
      scnt++;
      total++;
      if (scnt == depth[seg]) begin
         scnt = 0;
         seg++;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      chk("h_load_done", 32'(h_done), 32'(total >= HD));
      chk("ni_load_done", 32'(ni_done), 32'(total >= HD + NID));
      chk("w_load_done", 32'(w_done), 32'(total >= HD + NID + WD));
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic read_phase();
      int t;
      gat_ready = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         chk("no_early_mvalid", 32'(m_valid), 32'd0);
      end
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_s_ready", 32'(s_ready), 32'd0);
      chk("writes_drained", 32'(wq.size()), 32'd0);
      gat_ready = 1'b1;
      @(posedge clk);
      #1;
      gat_ready = 1'b0;
      chk("addrb_first", 32'(feat_bram_addrb), 32'd0);
      chk("no_mvalid_at_addr", 32'(m_valid), 32'd0);
      for (int i = 0; i < FD; i++) rq.push_back(32'hA0 + 32'(i));
      t = 0;
      while (!m_valid && t < 10) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("m_valid_rise", 32'(m_valid), 32'd1);
      repeat (5) begin
         chk("hold_valid", 32'(m_valid), 32'd1);
         chk("hold_data", m_data, 32'hA0);
         @(posedge clk);
         #1;
      end
      m_ready = 1'b1;
      t = 0;
      while (!done && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      m_ready = 1'b0;
      chk("run_done", 32'(done), 32'd1);
      chk("run_busy", 32'(busy), 32'd0);
      chk("results_drained", 32'(rq.size()), 32'd0);
   endtask

   initial begin
      vec       = 0;
      bad       = 0;
      rst       = 1'b1;
      start     = 1'b0;
      s_data    = '0;
      s_valid   = 1'b0;
      gat_ready = 1'b0;
      m_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", m_data, 32'd0);
      chk("rst_addrb", 32'(feat_bram_addrb), 32'd0);
      chk("rst_h_addra", 32'(h_addra), 32'd0);
      chk("rst_ena", {28'd0, sg_ena, w_ena, ni_ena, h_ena}, 32'd0);
      chk("rst_flags", {29'd0, w_done, ni_done, h_done}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back load of all segments.
      start_run();
      for (int i = 0; i < 11; i++) beat(32'h100 + 32'(i), 1'b0);
      chk("wait_gat_s_ready", 32'(s_ready), 32'd0);
      read_phase();

      // Start from DONE, gapped beats, then reset inside LD_W.
      start_run();
      for (int i = 0; i < 7; i++) beat(32'h200 + 32'(i), 1'b1);
      s_valid = 1'b1;
      s_data  = 32'h2FF;
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      s_valid = 1'b0;
      chk("midrst_flags", {29'd0, w_done, ni_done, h_done}, 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ena", {28'd0, sg_ena, w_ena, ni_ena, h_ena}, 32'd0);
      chk("midrst_w_addra", 32'(w_addra), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fresh run; a start pulse during LD_NI must be ignored.
      start_run();
      for (int i = 0; i < 11; i++) begin
         if (i == 5) start = 1'b1;
         beat(32'h300 + 32'(i), 1'b0);
         start = 1'b0;
      end
      chk("ignored_start_busy", 32'(busy), 32'd1);
      read_phase();

      // Restart from DONE: flags clear and writes restart at h_data 0.
      start_run();
      beat(32'h400, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("restart_drained", 32'(wq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation limit reached");
      $fatal(1, "timeout");
   end

endmodule
